writeback_stage: RTL and testbench

Back-end pipeline block: MEM and WB stage registers feeding the register file write port, plus the operand-forwarding and load-use hazard logic for the ID/EX read operands (Da/Db). An instruction enters from EX, spends one cycle in MEM, where it presents its address to data memory, and one cycle in WB, where it drives the register file write port. Register-match logic against both stages tells the EX operand muxes where the freshest Da/Db value lives. A retired-instruction counter supports performance checks.

---
 rtl/writeback_stage_pkg.sv | 32 +++
 rtl/writeback_stage_if.sv | 40 ++++
 rtl/writeback_stage_fwd_match.sv | 33 +++
 rtl/writeback_stage.sv | 97 +++++++++
 tb/tb_writeback_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the MEM/WB back end: stage register layouts
// and the operand-forwarding select encoding.
package writeback_stage_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 32;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memtoreg;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] result;
    } mem_stage_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_stage_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of the EX-side issue signals, data memory port, ID operand lookup
// and register file write port around the writeback stage.
interface writeback_stage_if #(
    parameter int CNT_W = 32
);
    import writeback_stage_pkg::*;

    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_memtoreg;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_W-1:0]  id_rn;
    logic [REG_W-1:0]  id_rm;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic [DATA_W-1:0] mem_fwd_data;
    logic              load_use;
    logic              RegWrite;
    logic [REG_W-1:0]  WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output ex_valid, ex_regwrite, ex_memtoreg, ex_rd, ex_result,
        output mem_rdata, id_rn, id_rm,
        input  mem_addr, fwd_a, fwd_b, mem_fwd_data, load_use,
        input  RegWrite, WriteRegister, WriteData, retire_count
    );

    modport slave (
        input  ex_valid, ex_regwrite, ex_memtoreg, ex_rd, ex_result,
        input  mem_rdata, id_rn, id_rm,
        output mem_addr, fwd_a, fwd_b, mem_fwd_data, load_use,
        output RegWrite, WriteRegister, WriteData, retire_count
    );

endinterface

// File: rtl/writeback_stage_fwd_match.sv
// Forwarding select for one ID source register: the MEM stage (younger) wins
// over WB, and loads still in MEM are never forwarded (load-use stalls instead).
module fwd_match
    import writeback_stage_pkg::*;
(
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [REG_W-1:0] src,
    output fwd_sel_t         sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid && mem_regwrite && !mem_memtoreg
                     && (mem_rd == src) && (src != ZERO_REG);
    // wb_write already excludes the zero register
    assign wb_hit  = wb_write && (wb_rd == src);

    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM and WB pipeline registers driving the register file write port, with
// EX operand forwarding, load-use detection and a retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int CNT_W = writeback_stage_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    writeback_stage_if.slave  bus
);

    mem_stage_t       mem_reg, mem_next;
    wb_stage_t        wb_reg, wb_next;
    logic [CNT_W-1:0] retire_reg;
    logic             reg_write;

    logic [REG_W-1:0] src_reg [2];
    fwd_sel_t         sel     [2];

    always_comb begin
        mem_next = mem_reg;
        if (!stall) begin
            mem_next = '{valid:    bus.ex_valid,
                         regwrite: bus.ex_regwrite,
                         memtoreg: bus.ex_memtoreg,
                         rd:       bus.ex_rd,
                         result:   bus.ex_result};
        end
        // a flushed instruction must never reach MEM, even while stalled
        if (flush) begin
            mem_next.valid = 1'b0;
        end
    end

    always_comb begin
        wb_next = wb_reg;
        if (stall) begin
            wb_next.valid = 1'b0;
        end else begin
            wb_next.valid    = mem_reg.valid;
            wb_next.regwrite = mem_reg.regwrite;
            wb_next.rd       = mem_reg.rd;
            wb_next.data     = mem_reg.memtoreg ? bus.mem_rdata : mem_reg.result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_reg    <= '0;
            wb_reg     <= '0;
            retire_reg <= '0;
        end else begin
            mem_reg <= mem_next;
            wb_reg  <= wb_next;
            if (wb_reg.valid) begin
                retire_reg <= retire_reg + CNT_W'(1);
            end
        end
    end

    assign reg_write = wb_reg.valid && wb_reg.regwrite && (wb_reg.rd != ZERO_REG);

    assign src_reg[0] = bus.id_rn;
    assign src_reg[1] = bus.id_rm;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_match u_fwd_match (
                .mem_valid    (mem_reg.valid),
                .mem_regwrite (mem_reg.regwrite),
                .mem_memtoreg (mem_reg.memtoreg),
                .mem_rd       (mem_reg.rd),
                .wb_write     (reg_write),
                .wb_rd        (wb_reg.rd),
                .src          (src_reg[gi]),
                .sel          (sel[gi])
            );
        end
    endgenerate

    assign bus.fwd_a        = sel[0];
    assign bus.fwd_b        = sel[1];
    assign bus.mem_addr     = mem_reg.result;
    assign bus.mem_fwd_data = mem_reg.result;
    assign bus.load_use     = mem_reg.valid && mem_reg.regwrite && mem_reg.memtoreg
                              && (mem_reg.rd != ZERO_REG)
                              && ((mem_reg.rd == bus.id_rn) || (mem_reg.rd == bus.id_rm));

    assign bus.RegWrite      = reg_write;
    assign bus.WriteRegister = wb_reg.rd;
    assign bus.WriteData     = wb_reg.data;
    assign bus.retire_count  = retire_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench: expected register writes go into a scoreboard queue at issue
// and are popped when RegWrite appears; a 4-bit-counter copy checks wrap.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_regwrite = 1'b0;
    logic        ex_memtoreg = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [63:0] ex_result = '0;
    logic [63:0] mem_rdata = '0;
    logic [4:0]  id_rn = '0;
    logic [4:0]  id_rm = '0;

    int checks = 0;
    int errors = 0;
    int issued = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    writeback_stage_if #(.CNT_W(32)) bus   ();
    writeback_stage_if #(.CNT_W(4))  bus_s ();

    assign bus.ex_valid      = ex_valid;
    assign bus.ex_regwrite   = ex_regwrite;
    assign bus.ex_memtoreg   = ex_memtoreg;
    assign bus.ex_rd         = ex_rd;
    assign bus.ex_result     = ex_result;
    assign bus.mem_rdata     = mem_rdata;
    assign bus.id_rn         = id_rn;
    assign bus.id_rm         = id_rm;
    assign bus_s.ex_valid    = ex_valid;
    assign bus_s.ex_regwrite = ex_regwrite;
    assign bus_s.ex_memtoreg = ex_memtoreg;
    assign bus_s.ex_rd       = ex_rd;
    assign bus_s.ex_result   = ex_result;
    assign bus_s.mem_rdata   = mem_rdata;
    assign bus_s.id_rn       = id_rn;
    assign bus_s.id_rm       = id_rm;

    writeback_stage #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus.slave)
    );

    writeback_stage #(.CNT_W(4)) dut_small (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus_s.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [4:0] rd, input logic [63:0] res);
        ex_valid    = v;
        ex_regwrite = rw;
        ex_memtoreg = m2r;
        ex_rd       = rd;
        ex_result   = res;
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // scoreboard: every register file write must match the oldest expected one
    always @(negedge clk) begin
        if (bus.RegWrite) begin
            $display("write rd=%0d data=%h", bus.WriteRegister, bus.WriteData);
            check("write_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_rd", 64'(bus.WriteRegister), 64'(w.rd));
                check("write_data", bus.WriteData, w.data);
            end
        end
    end

    initial begin
        // reset held with a valid instruction presented
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h55);
        id_rn = 5'd3;
        id_rm = 5'd3;
        tick();
        tick();
        check("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        check("rst_wreg", 64'(bus.WriteRegister), 64'd0);
        check("rst_wdata", bus.WriteData, 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_fwd_a", 64'(bus.fwd_a), 64'd0);
        check("rst_fwd_b", 64'(bus.fwd_b), 64'd0);
        check("rst_load_use", 64'(bus.load_use), 64'd0);
        check("rst_retire", 64'(bus.retire_count), 64'd0);

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        tick();

        // ALU write rd=3
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h55);
        push(5'd3, 64'h55);
        issued++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        id_rn = 5'd3;
        id_rm = 5'd0;
        #1;
        check("alu_mem_addr", bus.mem_addr, 64'h55);
        check("alu_mem_fwd", bus.mem_fwd_data, 64'h55);
        check("alu_fwd_a_mem", 64'(bus.fwd_a), 64'd2);
        check("alu_fwd_b_reg", 64'(bus.fwd_b), 64'd0);
        check("alu_no_early_write", 64'(bus.RegWrite), 64'd0);
        tick();
        #1;
        check("alu_regwrite", 64'(bus.RegWrite), 64'd1);
        check("alu_fwd_a_wb", 64'(bus.fwd_a), 64'd1);
        tick();
        check("alu_retire", 64'(bus.retire_count), 64'd1);
        check("alu_single_write", 64'(bus.RegWrite), 64'd0);

        // load rd=4
        drive(1'b1, 1'b1, 1'b1, 5'd4, 64'h100);
        push(5'd4, 64'hDEAD);
        issued++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        mem_rdata = 64'hDEAD;
        id_rn = 5'd0;
        id_rm = 5'd4;
        #1;
        check("ld_load_use", 64'(bus.load_use), 64'd1);
        check("ld_fwd_b_none", 64'(bus.fwd_b), 64'd0);
        check("ld_mem_addr", bus.mem_addr, 64'h100);
        id_rm = 5'd5;
        #1;
        check("ld_no_load_use", 64'(bus.load_use), 64'd0);
        id_rm = 5'd4;
        tick();
        #1;
        check("ld_wdata", bus.WriteData, 64'hDEAD);
        check("ld_fwd_b_wb", 64'(bus.fwd_b), 64'd1);
        check("ld_load_use_gone", 64'(bus.load_use), 64'd0);
        id_rm = 5'd0;

        // back-to-back writes to rd=7: MEM beats WB
        drive(1'b1, 1'b1, 1'b0, 5'd7, 64'h11);
        push(5'd7, 64'h11);
        issued++;
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd7, 64'h22);
        push(5'd7, 64'h22);
        issued++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        id_rn = 5'd7;
        #1;
        check("b2b_fwd_a_mem", 64'(bus.fwd_a), 64'd2);
        check("b2b_mem_fwd", bus.mem_fwd_data, 64'h22);
        tick();
        #1;
        check("b2b_fwd_a_wb", 64'(bus.fwd_a), 64'd1);

        // write to the zero register
        drive(1'b1, 1'b1, 1'b0, 5'd31, 64'h99);
        issued++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        id_rn = 5'd31;
        #1;
        check("xzr_fwd_a_mem", 64'(bus.fwd_a), 64'd0);
        tick();
        #1;
        check("xzr_regwrite", 64'(bus.RegWrite), 64'd0);
        check("xzr_fwd_a_wb", 64'(bus.fwd_a), 64'd0);
        tick();
        check("xzr_retire", 64'(bus.retire_count), 64'(issued));

        // stall three cycles with rd=9 in MEM
        drive(1'b1, 1'b1, 1'b0, 5'd9, 64'h77);
        push(5'd9, 64'h77);
        issued++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        stall = 1'b1;
        id_rn = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_bubble", 64'(bus.RegWrite), 64'd0);
            check("stall_hold_addr", bus.mem_addr, 64'h77);
        end
        #1;
        check("stall_fwd_a_mem", 64'(bus.fwd_a), 64'd2);
        stall = 1'b0;
        tick();
        check("stall_release_write", 64'(bus.RegWrite), 64'd1);
        check("stall_release_data", bus.WriteData, 64'h77);
        tick();
        check("stall_single_pulse", 64'(bus.RegWrite), 64'd0);

        // flush and stall together
        drive(1'b1, 1'b1, 1'b0, 5'd12, 64'h33);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        id_rn = 5'd12;
        #1;
        check("flush_fwd_a", 64'(bus.fwd_a), 64'd0);
        tick();
        tick();
        check("flush_no_write", 64'(bus.RegWrite), 64'd0);
        check("flush_retire", 64'(bus.retire_count), 64'(issued));
        check("small_retire", 64'(bus_s.retire_count), 64'(issued % 16));

        // run the 4-bit counter copy through its wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 5'(i), 64'(i));
            issued++;
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        tick();
        tick();
        check("wrap_main_retire", 64'(bus.retire_count), 64'd16);
        check("wrap_small_retire", 64'(bus_s.retire_count), 64'd0);

        // reset in the middle of an instruction
        drive(1'b1, 1'b1, 1'b0, 5'd13, 64'h44);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        reset = 1'b0;
        #1;
        check("midrst_mem_addr", bus.mem_addr, 64'd0);
        check("midrst_retire", 64'(bus.retire_count), 64'd0);
        tick();
        tick();
        check("midrst_no_write", 64'(bus.RegWrite), 64'd0);
        reset = 1'b1;
        tick();
        check("midrst_after_release", 64'(bus.RegWrite), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
